// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data requests win until a run of data grants forces a fetch grant.
module mem_arbiter #(
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        I_ACC,
        D_ACC,
        RESP
    } state_t;

    localparam logic [3:0] DMAX = 4'(MAX_D_BURST);

    state_t     state;
    logic [3:0] dcnt;
    logic       d_wins;

    // Data wins unless a fetch is waiting and the burst budget is spent.
    assign d_wins = d_req && (!if_req || (dcnt < DMAX));

    // The pipeline holds while any of its requests is still outstanding.
    assign stall = (if_req & ~if_done) | (d_req & ~d_done);

    // Arbitration, memory handshake and done pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_wins) begin
                        state     <= D_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_adr   <= d_adr;
                        mem_wdata <= d_wdata;
                        if (dcnt < DMAX)
                            dcnt <= dcnt + 4'd1;
                    end else if (if_req) begin
                        state     <= I_ACC;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_adr   <= if_adr;
                        mem_wdata <= '0;
                        dcnt      <= '0;
                    end
                end
                I_ACC: begin
                    if (mem_ack) begin
                        state    <= RESP;
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end
                end
                D_ACC: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_done  <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, contention,
// held requests, reset abort and stray acks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_adr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_adr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;

    int total = 0;
    int bad = 0;

    mem_arbiter #(.MAX_D_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_adr    (if_adr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_adr     (d_adr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read there too.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_adr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_adr     = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_done", 32'(if_done), 0);
        chk("rst_d_done", 32'(d_done), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b0;
        step();

        // Single fetch, ack one cycle after mem_req
        if_req = 1'b1;
        if_adr = 32'h40;
        #1;
        chk("f_stall_c0", 32'(stall), 1);
        step();
        chk("f_mem_req_c1", 32'(mem_req), 1);
        chk("f_mem_we_c1", 32'(mem_we), 0);
        chk("f_mem_adr_c1", mem_adr, 32'h40);
        step();
        chk("f_done_c2", 32'(if_done), 0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C010004;
        step();
        mem_ack = 1'b0;
        chk("f_if_done_c3", 32'(if_done), 1);
        chk("f_if_rdata_c3", if_rdata, 32'h8C010004);
        chk("f_stall_c3", 32'(stall), 0);
        chk("f_mem_req_c3", 32'(mem_req), 0);
        chk("f_d_done_c3", 32'(d_done), 0);
        if_req = 1'b0;
        step();
        chk("f_if_done_c4", 32'(if_done), 0);
        chk("f_if_rdata_hold", if_rdata, 32'h8C010004);

        // Store with a 3-cycle wait before ack
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_adr   = 32'h100;
        d_wdata = 32'hDEADBEEF;
        step();
        for (int c = 1; c <= 4; c++) begin
            chk("s_mem_req", 32'(mem_req), 1);
            chk("s_mem_we", 32'(mem_we), 1);
            chk("s_mem_adr", mem_adr, 32'h100);
            chk("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
            chk("s_d_done_wait", 32'(d_done), 0);
            chk("s_stall_wait", 32'(stall), 1);
            if (c == 4) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'h12345678;
            end
            step();
        end
        mem_ack = 1'b0;
        chk("s_d_done", 32'(d_done), 1);
        chk("s_d_rdata", d_rdata, 32'h12345678);
        chk("s_stall_done", 32'(stall), 0);
        d_req = 1'b0;
        d_we  = 1'b0;
        step();
        chk("s_d_done_single", 32'(d_done), 0);
        chk("s_mem_req_idle", 32'(mem_req), 0);

        // Request held high through its done cycle
        if_req = 1'b1;
        if_adr = 32'h80;
        step();
        chk("h_mem_req_c1", 32'(mem_req), 1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000AAAA;
        step();
        mem_ack = 1'b0;
        chk("h_if_done_c2", 32'(if_done), 1);
        chk("h_no_grant_resp", 32'(mem_req), 0);
        step();
        chk("h_idle_c3_req", 32'(mem_req), 0);
        chk("h_idle_c3_done", 32'(if_done), 0);
        chk("h_stall_c3", 32'(stall), 1);
        step();
        chk("h_regrant_c4", 32'(mem_req), 1);
        chk("h_regrant_adr", mem_adr, 32'h80);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("h_if_done_2", 32'(if_done), 1);
        if_req = 1'b0;
        step();

        // Reset asserted while in D_ACC
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_adr   = 32'h200;
        d_wdata = 32'hCAFEF00D;
        step();
        chk("r_in_dacc", 32'(mem_req), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("r_async_req", 32'(mem_req), 0);
        chk("r_async_we", 32'(mem_we), 0);
        chk("r_async_adr", mem_adr, 0);
        chk("r_async_wdata", mem_wdata, 0);
        chk("r_async_rdata", if_rdata, 0);
        step();
        reset   = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h55555555;
        step();
        mem_ack = 1'b0;
        chk("r_no_d_done", 32'(d_done), 0);
        chk("r_stray_req", 32'(mem_req), 0);
        chk("r_d_rdata_clear", d_rdata, 0);

        // Ack pulsed in IDLE with no requests
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        step();
        mem_ack = 1'b0;
        chk("a_if_done", 32'(if_done), 0);
        chk("a_d_done", 32'(d_done), 0);
        chk("a_d_rdata", d_rdata, 0);
        chk("a_if_rdata", if_rdata, 0);
        step();
        chk("a_mem_req", 32'(mem_req), 0);
        chk("a_d_done_2", 32'(d_done), 0);

        // Contention with burst limit 4, immediate ack
        do_reset();
        if_req  = 1'b1;
        if_adr  = 32'h1000;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_adr   = 32'h2000;
        d_wdata = 32'h0BADCAFE;
        for (int g = 0; g < 10; g++) begin
            automatic bit exp_i = (g == 4) || (g == 9);
            step();
            chk("c_mem_req", 32'(mem_req), 1);
            chk("c_mem_adr", mem_adr, exp_i ? 32'h1000 : 32'h2000);
            chk("c_mem_we", 32'(mem_we), exp_i ? 0 : 1);
            chk("c_mem_wdata", mem_wdata, exp_i ? 0 : 32'h0BADCAFE);
            mem_ack   = 1'b1;
            mem_rdata = 32'(g);
            step();
            mem_ack = 1'b0;
            chk("c_if_done", 32'(if_done), exp_i ? 1 : 0);
            chk("c_d_done", 32'(d_done), exp_i ? 0 : 1);
            chk("c_rdata", exp_i ? if_rdata : d_rdata, 32'(g));
            chk("c_resp_req", 32'(mem_req), 0);
            step();
            chk("c_idle_req", 32'(mem_req), 0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter shared by the pipeline's instruction-fetch port and its MEM-stage data port, so that one unified memory can replace separate instruction and data memories. The block accepts one request per port, and grants a port the memory for one transaction at a time. It uses a multi-cycle ack handshake toward memory and returns a one-cycle done pulse to the winning port. It also drives the pipeline stall signal. Data requests normally win; a starvation counter forces an instruction grant after a bounded run of data grants.

## Interface
- MAX_D_BURST, 4: consecutive data grants allowed while if_req is pending before the instruction port is forced a grant; range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction-fetch request; held until if_done.
- if_adr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid only while if_done=1.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_adr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid only while d_done=1.
- d_done  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory transaction request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_adr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the mem_ack cycle.
- mem_ack  in  1  memory completion; one cycle.
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).

## Operation
- State machine with states IDLE, I_ACC, D_ACC, and RESP.
- **IDLE:**
  - d_req only: go to D_ACC. dcnt increments, saturating at MAX_D_BURST.
  - if_req only: go to I_ACC. dcnt clears to 0.
  - Both requests and dcnt < MAX_D_BURST: go to D_ACC. dcnt increments.
  - Both requests and dcnt == MAX_D_BURST: go to I_ACC. dcnt clears to 0.
  - Neither request: stay in IDLE.
- On grant, the arbiter registers the winner's address, we, and wdata into mem_adr, mem_we, and mem_wdata. An instruction grant forces mem_we=0 and mem_wdata=0. These values stay stable until the state leaves I_ACC or D_ACC.
- **I_ACC / D_ACC:** mem_req=1. On mem_ack, the arbiter registers mem_rdata into if_rdata or d_rdata, records the winning port, and goes to RESP.
- **RESP:** pulses if_done or d_done for the recorded port, then goes to IDLE unconditionally. No new arbitration happens in RESP, so a request still high in the done cycle is not re-granted.
- mem_ack is ignored in IDLE and RESP.
- A requester that drops its req mid-transaction is a protocol violation. The transaction still completes and the done pulse still fires.
- if_rdata and d_rdata hold their last value outside the done cycle. Consumers use them only in the done cycle.
- Stores return d_done the same way as loads. d_rdata then carries the mem_rdata value sampled at ack.
- dcnt width is 4 bits.

## Timing
- **Reset values:** state=IDLE, dcnt=0. mem_req, mem_we, if_done, and d_done are 0. mem_adr, mem_wdata, if_rdata, and d_rdata are 0.
- Reset asserted mid-transaction aborts immediately and returns to IDLE. No done pulse is issued for the aborted transaction.
- **Latency:** req first seen in cycle 0 → mem_req high in cycle 1. mem_ack in cycle k (k≥1) → done high in cycle k+1 → arbitration resumes in cycle k+2.
- Minimum latency is 2 cycles, request to done. Maximum throughput is one transaction per 3 cycles.
- mem_req rises in the cycle after grant and falls in the cycle after mem_ack.
- stall is high from cycle 0 and low in the done cycle. This lets the pipeline advance on that clock edge.
- **Starvation bound:** with both ports requesting continuously, the arbiter grants MAX_D_BURST data transactions and then one instruction transaction, repeating.

## Test plan
- **Single fetch:** if_req=1, if_adr=0x40, mem_ack one cycle after mem_req with mem_rdata=0x8C010004. Required: mem_req in cycle 1, mem_we=0, mem_adr=0x40, if_done with if_rdata=0x8C010004 in cycle 3, stall low in cycle 3.
- **Store:** d_req=1, d_we=1, d_adr=0x100, d_wdata=0xDEADBEEF, mem_ack with 3-cycle wait. Required: mem_we=1, mem_adr=0x100, and mem_wdata=0xDEADBEEF held stable through ack; a single d_done pulse follows.
- **Contention:** MAX_D_BURST=4, both requests held high, each requester re-asserts after its done, mem_ack immediate. Required grant order D,D,D,D,I,D,D,D,D,I, and one grant every 3 cycles.
- **Held request in RESP:** the requester keeps req high during its done cycle. Required: no grant in the RESP cycle; the next grant happens from IDLE one cycle later.
- **Reset mid-transaction:** reset pulsed while in D_ACC, then mem_ack arrives. Required: all outputs return to 0 immediately, no d_done, and the stray mem_ack is ignored in IDLE.
- **Ack outside a transaction:** mem_ack pulsed in IDLE with no requests. Required: no done pulse and no state change.
